counter_checker: RTL
====================

# counter_checker

Self-checking monitor that sits beside the 8-bit up/down/load counter and consumes its control inputs and `q` output. Each cycle it predicts the next `q` from the current observed `q` and the sampled controls, compares on the following edge, and reports per-cycle mismatches, a saturating error count, and a capture of the first failure. Instantiated in counter benches and, optionally, in silicon debug builds as a live integrity monitor.

## Interface
- `W`, 8, counter width
- `ERR_W`, 8, error-counter width (saturating)
- `CHK_W`, 16, check-counter width (saturating)

- `clk`  in  1  clock; same clock as the counter
- `rst`  in  1  asynchronous, active-low reset of the checker only
- `en`  in  1  checker enable; 0 = no compares, state returns to ARM
- `dut_clr`  in  1  counter's clear is asserted this cycle (active-high, as seen on the counter)
- `load`  in  1  counter load strobe
- `load_val`  in  W  value loaded when `load`=1
- `updown`  in  1  1 = count up, 0 = count down
- `q`  in  W  observed counter output
- `err_clr`  in  1  synchronous clear of `err_cnt`, `fail`, captures
- `mismatch`  out  1  one-cycle pulse: compare failed this edge
- `fail`  out  1  sticky; set on first mismatch
- `err_cnt`  out  ERR_W  mismatches since reset/`err_clr`, saturates at all-ones
- `chk_cnt`  out  CHK_W  compares performed, saturates at all-ones
- `first_exp`  out  W  predicted value at first mismatch
- `first_got`  out  W  observed `q` at first mismatch
- `armed`  out  1  1 when in CHECK state

## Operation
- States: ARM, CHECK.
- ARM: no compare. On an edge with `en`=1, compute `pred` and go to CHECK.
- CHECK: on each edge with `en`=1, compare `q` to `pred`, then recompute `pred`. On `en`=0, go to ARM; `pred` is don't-care.
- Prediction priority, evaluated at edge k and compared at edge k+1:
  - `dut_clr` gives 0.
  - Otherwise `load` gives `load_val`.
  - Otherwise `updown`=1 gives `q`+1; `updown`=0 gives `q`-1.
- Arithmetic is modulo 2^W. `q`=8'hFF up predicts 8'h00. `q`=8'h00 down predicts 8'hFF.
- The base for each prediction is the observed `q`, not the prior prediction, so one fault produces one mismatch, with no cascade.
- On a compare:
  - `chk_cnt` increments (saturating).
  - On inequality: pulse `mismatch`, increment `err_cnt` (saturating), set `fail`.
  - If `fail` was 0, also latch `first_exp`/`first_got`.
- `err_clr` clears `err_cnt`, `fail`, `first_exp`, `first_got` and `chk_cnt`, and has priority over an update on the same edge. The compare itself still happens; its result is discarded from the counters. `mismatch` still pulses if unequal.
- `err_clr` does not affect state or `pred`.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state ARM, `pred`=0
  - `mismatch`=0, `fail`=0, `armed`=0
  - `err_cnt`=0, `chk_cnt`=0
  - `first_exp`=0, `first_got`=0
- Release is synchronous to the next `clk` rise.
- Latency: controls sampled at edge k are checked against `q` at edge k+1. `mismatch` is registered and visible after edge k+1, high for exactly one cycle per failing compare.
- First compare occurs at the second enabled edge after ARM.
- `armed` rises after the first enabled edge.
- Controls and `q` must be stable around the sampling edge; the checker adds no synchronisers.
- Counter saturation:
  - `err_cnt` holds at 2^ERR_W-1 and `mismatch` still pulses.
  - `chk_cnt` holds at 2^CHK_W-1.
- Reset mid-run discards `pred` and all captures.
- `en` low for one cycle re-arms, costing one compare.

## Test plan
- Reset/arm: `rst`=0 then release, `en`=1, `updown`=1, `q` tracks 0,1,2,3. Expect `armed`=1 after edge 1, `chk_cnt`=3 after edge 4, `mismatch`=0, `fail`=0.
- Wrap both ways:
  - `q`=8'hFE, 8'hFF, 8'h00 with `updown`=1: no mismatch.
  - `q`=8'h01, 8'h00, 8'hFF with `updown`=0: no mismatch.
- Priority: `dut_clr`=1, `load`=1, `load_val`=8'h5A, `q`=8'h10. Next `q`=8'h00 passes; next `q`=8'h5A gives `mismatch`=1.
- Single fault: counting up 8'h20, 8'h21, then `q` glitches to 8'h30, then 8'h31. Expect:
  - exactly one `mismatch` pulse
  - `err_cnt`=1, `fail`=1
  - `first_exp`=8'h22, `first_got`=8'h30
- Saturation and clear:
  - Drive 260 consecutive failing compares: `err_cnt`=8'hFF, `mismatch` pulses on each compare.
  - Then `err_clr` for one cycle: all counters, `fail` and captures read 0; state stays CHECK.
- Reset mid-operation: assert `rst`=0 asynchronously between edges while `fail`=1. Outputs clear immediately; after release, the first compare occurs at the second enabled edge.

Source files
------------

// File: rtl/counter_checker.sv
// Live integrity monitor for an 8-bit up/down/load counter: predicts the next q
// from the observed q and controls, compares one edge later, and logs failures.
module counter_checker #(
    parameter int W     = 8,
    parameter int ERR_W = 8,
    parameter int CHK_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dut_clr,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             updown,
    input  logic [W-1:0]     q,
    input  logic             err_clr,
    output logic             mismatch,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CHK_W-1:0] chk_cnt,
    output logic [W-1:0]     first_exp,
    output logic [W-1:0]     first_got,
    output logic             armed
);

    typedef enum logic {
        ST_ARM   = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_pred;
    logic               r_mismatch;
    logic               r_fail;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [CHK_W-1:0]   r_chk_cnt;
    logic [W-1:0]       r_first_exp;
    logic [W-1:0]       r_first_got;
    logic               r_armed;

    logic [W-1:0]       w_pred_next;
    logic               w_compare;
    logic               w_neq;

    // Next counter value; the base is always the observed q so a single fault
    // cannot cascade into later compares.
    function automatic logic [W-1:0] predict_next(
        input logic         f_clr,
        input logic         f_load,
        input logic [W-1:0] f_load_val,
        input logic         f_up,
        input logic [W-1:0] f_q
    );
        logic [W-1:0] v;
        if (f_clr) begin
            v = {W{1'b0}};
        end else if (f_load) begin
            v = f_load_val;
        end else if (f_up) begin
            v = f_q + W'(1);
        end else begin
            v = f_q - W'(1);
        end
        return v;
    endfunction

    // Prediction and compare qualification for the current edge.
    always_comb begin
        w_pred_next = predict_next(dut_clr, load, load_val, updown, q);
        w_compare   = en && (r_state == ST_CHECK);
        w_neq       = (q != r_pred);
    end

    // Checker state, prediction register, counters and first-failure capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_ARM;
            r_pred      <= {W{1'b0}};
            r_mismatch  <= 1'b0;
            r_fail      <= 1'b0;
            r_err_cnt   <= {ERR_W{1'b0}};
            r_chk_cnt   <= {CHK_W{1'b0}};
            r_first_exp <= {W{1'b0}};
            r_first_got <= {W{1'b0}};
            r_armed     <= 1'b0;
        end else begin
            if (en) begin
                r_state <= ST_CHECK;
                r_armed <= 1'b1;
                r_pred  <= w_pred_next;
            end else begin
                r_state <= ST_ARM;
                r_armed <= 1'b0;
            end

            // The pulse is reported even when err_clr discards the counters.
            r_mismatch <= w_compare && w_neq;

            if (err_clr) begin
                r_fail      <= 1'b0;
                r_err_cnt   <= {ERR_W{1'b0}};
                r_chk_cnt   <= {CHK_W{1'b0}};
                r_first_exp <= {W{1'b0}};
                r_first_got <= {W{1'b0}};
            end else if (w_compare) begin
                if (r_chk_cnt != {CHK_W{1'b1}}) begin
                    r_chk_cnt <= r_chk_cnt + CHK_W'(1);
                end else begin
                    r_chk_cnt <= r_chk_cnt;
                end
                if (w_neq) begin
                    r_fail <= 1'b1;
                    if (r_err_cnt != {ERR_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + ERR_W'(1);
                    end else begin
                        r_err_cnt <= r_err_cnt;
                    end
                    if (!r_fail) begin
                        r_first_exp <= r_pred;
                        r_first_got <= q;
                    end else begin
                        r_first_exp <= r_first_exp;
                        r_first_got <= r_first_got;
                    end
                end else begin
                    r_fail <= r_fail;
                end
            end else begin
                r_fail <= r_fail;
            end
        end
    end

    assign mismatch  = r_mismatch;
    assign fail      = r_fail;
    assign err_cnt   = r_err_cnt;
    assign chk_cnt   = r_chk_cnt;
    assign first_exp = r_first_exp;
    assign first_got = r_first_got;
    assign armed     = r_armed;

endmodule
